knn_feeder: RTL
===============

# knn_feeder

Sample-stream initiator for `knn_core`. Accepts 32-bit samples pushed by the CPU register interface into a small FIFO and presents them one per cycle on the core's `x`/`en` inputs. Primes the core's three-deep sample window after every clear, then captures each 64-bit `{y_high, y_low}` result into a one-deep holding register for the CPU to read. Stalls the sample stream while an unread result is held.

## Interface
Parameters:
- `DATA_W`, 32: sample and result-half width.
- `FIFO_ADDR_W`, 3: log2 of the sample FIFO depth (8 entries).
- `PRIME_N`, 3: number of samples issued after clear whose results are discarded.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `clear` in 1: synchronous soft clear.
- `push` in 1: write `wdata` into the FIFO.
- `wdata` in DATA_W: sample to push.
- `full` out 1: FIFO full.
- `count` out FIFO_ADDR_W+1: FIFO occupancy, 0..8.
- `overflow` out 1: sticky; a push was dropped while full.
- `pop_result` in 1: CPU has consumed the held result.
- `res_valid` out 1: holding register contains an unread result.
- `res_high` out DATA_W: result bits 63:32.
- `res_low` out DATA_W: result bits 31:0.
- `core_en` out 1: drives `knn_core.en`.
- `core_x` out DATA_W: drives `knn_core.x`.
- `core_y_high` in DATA_W: from `knn_core.y_high`.
- `core_y_low` in DATA_W: from `knn_core.y_low`.

## Operation
- FSM with two states:
  - PRIME: the window is filling.
  - RUN: results are captured.
- Reset and clear both enter PRIME with `prime_cnt`=0.
- Issue condition `issue` = FIFO non-empty AND (state==PRIME OR !res_valid OR pop_result).
- `core_en` = `issue` (combinational). `core_x` = FIFO head. `core_x` = 0 when the FIFO is empty.
- On `issue` in PRIME:
  - Pop the FIFO and increment `prime_cnt`.
  - Discard the core output.
  - When `prime_cnt` reaches PRIME_N-1 on this issue, go to RUN.
- On `issue` in RUN:
  - Pop the FIFO.
  - Load `{res_high,res_low}` ← `{core_y_high,core_y_low}`.
  - Set `res_valid`=1.
- Result handling:
  - `pop_result` with no issue clears `res_valid`.
  - `pop_result` together with an issue loads the new result and keeps `res_valid`=1.
  - `pop_result` while `res_valid`=0 is ignored.
- `push` while `full` is dropped and sets `overflow`. The full check uses the pre-edge state, so a simultaneous pop does not admit the push. Otherwise a push and pop in the same cycle leave `count` unchanged.
- `clear`:
  - Empties the FIFO and zeroes `res_valid`, `overflow` and `prime_cnt`.
  - Forces PRIME and suppresses `issue` that cycle.
  - Has priority over `push` and `pop_result`.
  - Does not reset the core's internal registers; priming flushes them instead.
- FIFO pointers wrap modulo 8. `full` = (`count`==8).

## Timing
- Reset values: `full`=0, `count`=0, `overflow`=0, `res_valid`=0, `res_high`=0, `res_low`=0, `core_en`=0, `core_x`=0. State is PRIME.
- A sample pushed at edge N is at the FIFO head in cycle N+1. The earliest issue is cycle N+1.
- The result of an issue in cycle M is visible on `res_*` with `res_valid`=1 from cycle M+1.
- Throughput is one sample per cycle while the CPU pops each result in the cycle after it appears.
- Mid-operation reset or clear: no further `core_en` until new samples arrive. The next PRIME_N samples are discarded.

## Structure
- Shared package `knn_pkg` holds:
  - the state encoding (PRIME, RUN);
  - defaults for `DATA_W`, `FIFO_ADDR_W` and `PRIME_N`.
- Sub-module `knn_sync_fifo`: a parameterised synchronous FIFO with push, pop, full, empty and count, reset asynchronously.
- The FSM, prime counter and result register stay in `knn_feeder`.

## Test plan
Each scenario is run with the feeder wired to a real `knn_core`.
- **Basic:** after reset, push 1,2,3,4 on consecutive cycles.
  - Expect `core_en` for exactly 4 cycles and one result: `res_high`=0, `res_low`=14.
  - `res_valid` rises one cycle after the 4th issue.
- **Wide result:** clear, then push 0xFFFFFFFF four times.
  - Expect `res_high`=0xFFFFFFFC, `res_low`=0x00000002.
- **Backpressure:** after reset, push 1..6 and withhold `pop_result`.
  - Result 14 is held, `core_en` stays low and `count`=2.
  - Pop: next `res_low`=26. Pop again: `res_low`=42, then `count`=0.
- **Overflow:** reset, push 1..4 without popping (result held), then push 9 more words.
  - `full`=1 after the 8th extra word. The 9th push is dropped, `overflow`=1 and `count`=8.
- **Simultaneous pop and issue:** with a result held and samples queued, assert `pop_result`.
  - Expect `res_valid` to stay 1, the new result to load the same edge, and `core_en`=1 that cycle.
- **Clear mid-stream:** push 1..5, clear after the 4th issue, then push 7,8,9,10.
  - After clear, `res_valid`=0 and `count`=0.
  - Only one further result is produced: `res_low`=10·9+8·7=146.

Source files
------------

// File: rtl/knn_pkg.sv
// Shared definitions for the knn_core sample feeder: FSM encoding and
// default parameter values.
package knn_pkg;

   localparam int DATA_W_DEF      = 32;
   localparam int FIFO_ADDR_W_DEF = 3;
   localparam int PRIME_N_DEF     = 3;

   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

endpackage

// File: rtl/knn_feeder_if.sv
// CPU-side sample/result handshake plus the knn_core x/en/y connection.
// The slave modport is the feeder; the master modport is the CPU and core side.
interface knn_feeder_if import knn_pkg::*; #(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int FIFO_ADDR_W = FIFO_ADDR_W_DEF
);
   logic                   push;
   logic [DATA_W-1:0]      wdata;
   logic                   full;
   logic [FIFO_ADDR_W:0]   count;
   logic                   overflow;
   logic                   pop_result;
   logic                   res_valid;
   logic [DATA_W-1:0]      res_high;
   logic [DATA_W-1:0]      res_low;
   logic                   core_en;
   logic [DATA_W-1:0]      core_x;
   logic [DATA_W-1:0]      core_y_high;
   logic [DATA_W-1:0]      core_y_low;

   modport slave (
      input  push, wdata, pop_result, core_y_high, core_y_low,
      output full, count, overflow, res_valid, res_high, res_low, core_en, core_x
   );

   modport master (
      output push, wdata, pop_result, core_y_high, core_y_low,
      input  full, count, overflow, res_valid, res_high, res_low, core_en, core_x
   );
endinterface

// File: rtl/knn_sync_fifo.sv
// Synchronous FIFO with occupancy count. Full/empty are judged on the
// pre-edge state, so a push into a full FIFO is refused even if it pops.
module knn_sync_fifo #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count == (ADDR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop_ok)
            count <= count + 1'b1;
         else if (pop_ok && !push_ok)
            count <= count - 1'b1;
      end
   end

   // Storage needs no reset: the head is never observed while empty.
   always_ff @(posedge clk) begin
      if (push_ok && !clr) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/knn_feeder.sv
// Feeds queued samples into knn_core one per cycle, discards the results of
// the priming samples after each clear, and holds each later result for the CPU.
module knn_feeder import knn_pkg::*; #(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int FIFO_ADDR_W = FIFO_ADDR_W_DEF,
   parameter int PRIME_N     = PRIME_N_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   knn_feeder_if.slave  bus
);
   localparam int PCW = $clog2(PRIME_N + 1);

   state_t              state;
   state_t              state_nxt;
   logic [PCW-1:0]      prime_cnt;
   logic [PCW-1:0]      prime_nxt;
   logic                res_ld;
   logic                issue;

   logic [DATA_W-1:0]   head;
   logic                fifo_empty;
   logic                fifo_full;
   logic [FIFO_ADDR_W:0] fifo_count;

   logic                overflow_q;
   logic                res_valid_q;
   logic [DATA_W-1:0]   res_high_q;
   logic [DATA_W-1:0]   res_low_q;

   knn_sync_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (FIFO_ADDR_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clear),
      .push  (bus.push && !clear),
      .pop   (issue),
      .wdata (bus.wdata),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A held result blocks the stream unless the CPU takes it this same cycle.
   assign issue = !fifo_empty && !clear &&
                  (state == ST_PRIME || !res_valid_q || bus.pop_result);

   assign bus.core_en   = issue;
   assign bus.core_x    = fifo_empty ? '0 : head;
   assign bus.full      = fifo_full;
   assign bus.count     = fifo_count;
   assign bus.overflow  = overflow_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_high  = res_high_q;
   assign bus.res_low   = res_low_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_PRIME;
         prime_cnt <= '0;
      end else begin
         state     <= state_nxt;
         prime_cnt <= prime_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      prime_nxt = prime_cnt;
      res_ld    = 1'b0;
      if (clear) begin
         state_nxt = ST_PRIME;
         prime_nxt = '0;
      end else begin
         case (state)
            ST_PRIME: begin
               if (issue) begin
                  prime_nxt = prime_cnt + 1'b1;
                  if (prime_cnt == PCW'(PRIME_N - 1)) state_nxt = ST_RUN;
               end
            end
            ST_RUN: begin
               res_ld = issue;
            end
            default: begin
               state_nxt = ST_PRIME;
               prime_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid_q <= 1'b0;
         res_high_q  <= '0;
         res_low_q   <= '0;
      end else if (clear) begin
         res_valid_q <= 1'b0;
      end else if (res_ld) begin
         res_valid_q <= 1'b1;
         res_high_q  <= bus.core_y_high;
         res_low_q   <= bus.core_y_low;
      end else if (bus.pop_result) begin
         res_valid_q <= 1'b0;
      end
   end

   // Dropped pushes are judged against pre-edge fullness.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         overflow_q <= 1'b0;
      else if (clear)
         overflow_q <= 1'b0;
      else if (bus.push && fifo_full)
         overflow_q <= 1'b1;
   end

endmodule
